// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// core's instruction-fetch port and its data (load/store) port. Data has
// priority; a starvation counter hands fetch one grant after STARVE_MAX
// consecutive denied cycles. Each read response is steered back to the port
// that issued it one cycle earlier.
//
// Optional build feature: define UNIFIED_MEM_ARBITER_PERF_EN to add the
// conflict_cnt / starve_hits performance counters. Arbitration is the same
// with or without the macro.
//
// STARVE_MAX must lie in 1..15 so that it fits the 4-bit starvation counter.

module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    // instruction fetch port (read only)
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // SRAM macro
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [15:0]       starve_hits
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_NONE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } resp_state_t;

    resp_state_t r_state;
    logic [3:0]  r_starve_cnt;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_starve_ovr;
    logic        w_i_win;
    logic        w_d_win;

    // Only the word-address bits reach the SRAM; the rest are ignored.
    logic        w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                  d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Arbitration: data first unless fetch has been denied STARVE_MAX cycles.
    // Grants are suppressed while reset is asserted so the SRAM stays idle.
    always_comb begin
        w_starve_ovr = (r_starve_cnt == STARVE_LIM);
        w_i_win      = 1'b0;
        w_d_win      = 1'b0;
        if (!Reset_n) begin
            w_i_win = 1'b0;
            w_d_win = 1'b0;
        end else if (i_req && (!d_req || w_starve_ovr)) begin
            w_i_win = 1'b1;
        end else if (d_req) begin
            w_d_win = 1'b1;
        end else begin
            w_i_win = 1'b0;
            w_d_win = 1'b0;
        end
    end

    assign i_gnt = w_i_win;
    assign d_gnt = w_d_win;

    // SRAM drive: the winner's request goes straight to the macro this cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        if (w_i_win) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = i_addr[ADDR_W+1:2];
        end else if (w_d_win) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_we ? d_be : 4'hF;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Response FSM: remember who owns the read issued this cycle and capture
    // the delivered word so it can be held until the next response.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_NONE;
            r_i_rdata <= 32'h0000_0000;
            r_d_rdata <= 32'h0000_0000;
        end else begin
            if (w_i_win) begin
                r_state <= ST_RESP_I;
            end else if (w_d_win && !d_we) begin
                r_state <= ST_RESP_D;
            end else begin
                r_state <= ST_NONE;
            end
            case (r_state)
                ST_RESP_I: r_i_rdata <= mem_rdata;
                ST_RESP_D: r_d_rdata <= mem_rdata;
                default: begin
                    r_i_rdata <= r_i_rdata;
                    r_d_rdata <= r_d_rdata;
                end
            endcase
        end
    end

    // Response outputs: live SRAM data during the response cycle, held value otherwise.
    always_comb begin
        i_rvalid = (r_state == ST_RESP_I);
        d_rvalid = (r_state == ST_RESP_D);
        i_rdata  = i_rvalid ? mem_rdata : r_i_rdata;
        d_rdata  = d_rvalid ? mem_rdata : r_d_rdata;
    end

    // Starvation counter: counts consecutive denied fetch cycles, saturating.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!i_req || w_i_win) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt < STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [15:0] r_starve_hits;

    // Performance counters: contention cycles (wrapping) and override grants (saturating).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_conflict_cnt <= 32'd0;
            r_starve_hits  <= 16'd0;
        end else begin
            if (i_req && d_req) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end else begin
                r_conflict_cnt <= r_conflict_cnt;
            end
            if (w_i_win && d_req && w_starve_ovr && (r_starve_hits != 16'hFFFF)) begin
                r_starve_hits <= r_starve_hits + 16'd1;
            end else begin
                r_starve_hits <= r_starve_hits;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign starve_hits  = r_starve_hits;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter with a behavioural write-first
// SRAM. Expected read data is queued per port when a read is issued; a
// monitor pops and compares whenever the DUT asserts an rvalid.

module tb_unified_mem_arbiter;

    localparam int ADDR_W = 12;

    logic              Clk;
    logic              Reset_n;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    logic [31:0]       conflict_cnt;
    logic [15:0]       starve_hits;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] wtmp;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .starve_hits  (starve_hits)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Write-first SRAM with one cycle of read latency.
    always @(posedge Clk) begin
        if (mem_en) begin
            wtmp = mem[mem_addr];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                mem[mem_addr] <= wtmp;
            end
            mem_rdata <= wtmp;
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (i_rvalid) begin
                if (iq.size() == 0) check("unexpected i_rvalid", 32'(i_rvalid), 32'd0);
                else check("i_rdata", i_rdata, iq.pop_front());
            end
            if (d_rvalid) begin
                if (dq.size() == 0) check("unexpected d_rvalid", 32'(d_rvalid), 32'd0);
                else check("d_rdata", d_rdata, dq.pop_front());
            end
        end
    end

    // One cycle: check grants (and SRAM drive when granted), then advance.
    task automatic step(input logic exp_i, input logic exp_d, input logic exp_we,
                        input logic [3:0] exp_be, input logic [31:0] exp_addr,
                        input string tag);
        @(negedge Clk);
        check({tag, " i_gnt"}, 32'(i_gnt), 32'(exp_i));
        check({tag, " d_gnt"}, 32'(d_gnt), 32'(exp_d));
        check({tag, " mem_en"}, 32'(mem_en), 32'(exp_i | exp_d));
        if (exp_i | exp_d) begin
            check({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
            check({tag, " mem_be"}, 32'(mem_be), 32'(exp_be));
            check({tag, " mem_addr"}, 32'(mem_addr), exp_addr);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 32'h0;
        mem[0]  = 32'h0000_0011;
        mem[1]  = 32'h0000_0022;
        mem[2]  = 32'h0000_0033;
        mem[32] = 32'h1122_3344;
        mem_rdata = 32'h0;
        idle();
        Reset_n = 1'b0;
        i_req   = 1'b1;

        // Reset state: no grant, no SRAM access, outputs zero
        @(negedge Clk);
        check("rst i_gnt", 32'(i_gnt), 32'd0);
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst i_rdata", i_rdata, 32'h0);
        check("rst d_rdata", d_rdata, 32'h0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, "idle0");

        // Fetch only, back-to-back
        i_req = 1'b1; i_addr = 32'h0; iq.push_back(32'h11);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, "fetch0");
        i_addr = 32'h4; iq.push_back(32'h22);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h1, "fetch1");
        i_addr = 32'h8; iq.push_back(32'h33);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h2, "fetch2");
        idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, "idle1");

        // Store then immediate load of the same word
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, "store40");
        d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0; dq.push_back(32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, "load40");
        idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, "idle2");

        // Contention: data x4, starvation override to fetch, then data again
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int c = 0; c < 4; c++) begin
            dq.push_back(32'hDEAD_BEEF);
            step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, $sformatf("cont%0d", c));
        end
        iq.push_back(32'h11);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, "cont4");
        dq.push_back(32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, "cont5");
        idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, "idle3");

        // Interleaved ownership: fetch then load, fetch data held afterwards
        i_req = 1'b1; i_addr = 32'h8; iq.push_back(32'h33);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h2, "ilv_f");
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h40; dq.push_back(32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, "ilv_d");
        idle();
        @(negedge Clk);
        check("ilv i_rvalid low", 32'(i_rvalid), 32'd0);
        check("ilv i_rdata hold", i_rdata, 32'h33);
        @(posedge Clk); #1;

        // Reset while a fetch read is in flight
        i_req = 1'b1; i_addr = 32'h4;
        @(negedge Clk);
        check("rst2 i_gnt", 32'(i_gnt), 32'd1);
        #2;
        Reset_n = 1'b0;
        idle();
        @(negedge Clk);
        check("rst2 i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst2 d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst2 i_rdata", i_rdata, 32'h0);
        check("rst2 d_rdata", d_rdata, 32'h0);
        check("rst2 mem_en", 32'(mem_en), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h4; iq.push_back(32'h22);
        step(1'b1, 1'b0, 1'b0, 4'hF, 32'h1, "post_rst");
        idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, "idle4");

        // Byte-lane store into 0x11223344, then load back
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h80; d_wdata = 32'h0000_AB00;
        step(1'b0, 1'b1, 1'b1, 4'b0010, 32'h20, "bstore");
        d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0; dq.push_back(32'h1122_AB44);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h20, "bload");
        idle();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, "drain");

        check("i queue drained", 32'(iq.size()), 32'd0);
        check("d queue drained", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
